// File: rtl/ix_stage.sv
// ix_stage: execute stage -- ALU, branch/jump resolution, registered IX/MEM outputs.
// Define IX_MULT_EN to build the iterative MULTU engine and the HI/LO register pair.
module ix_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] ir_in,
  input  logic [31:0] A_in,
  input  logic [31:0] B_in,
  input  logic [5:0]  alu_op_in,
  input  logic        is_branch_in,
  input  logic        is_jump_in,
  input  logic        op2_sel_in,
  input  logic [5:0]  shift_amount_in,
  input  logic [1:0]  branch_type_in,
  output logic        stall_out,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] ir_out,
  output logic [31:0] result_out,
  output logic [31:0] B_out,
  output logic        branch_taken_out,
  output logic [31:0] branch_target_out
);
  localparam logic [5:0] OP_ADD  = 6'h00, OP_SUB = 6'h01, OP_AND = 6'h02, OP_OR  = 6'h03,
                         OP_XOR  = 6'h04, OP_NOR = 6'h05, OP_SLT = 6'h06, OP_SLTU = 6'h07,
                         OP_SLL  = 6'h08, OP_SRL = 6'h09, OP_SRA = 6'h0A, OP_LUI = 6'h0B;

  logic [31:0] w_imm, w_op2, w_alu, w_br_tgt, w_j_tgt;
  logic [4:0]  w_sh;
  logic        w_cond, w_taken, w_stall;
  logic        w_unused;

  assign w_unused = shift_amount_in[5];
  assign w_sh     = shift_amount_in[4:0];
  assign w_imm    = {{16{ir_in[15]}}, ir_in[15:0]};
  assign w_op2    = op2_sel_in ? w_imm : B_in;
  assign w_br_tgt = pc_in + 32'd4 + {w_imm[29:0], 2'b00};
  assign w_j_tgt  = {pc_in[31:28], ir_in[25:0], 2'b00};

`ifdef IX_MULT_EN
  localparam logic [5:0] OP_MULTU = 6'h10, OP_MFHI = 6'h11, OP_MFLO = 6'h12;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  state_t      r_state;
  logic [63:0] r_acc, r_mcand;
  logic [31:0] r_mplier, r_hi, r_lo;
  logic [4:0]  r_cnt;
  logic [63:0] w_acc_next;

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  // Gated by rst_n so the stall drops the instant reset asserts, even with MULTU presented.
  assign w_stall = rst_n & (((r_state == S_IDLE) & valid_in & (alu_op_in == OP_MULTU)) |
                            (r_state == S_BUSY));

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_acc    <= 64'd0;
      r_mcand  <= 64'd0;
      r_mplier <= 32'd0;
      r_cnt    <= 5'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: if (w_stall) begin
          r_mcand  <= {32'd0, A_in};
          r_mplier <= B_in;
          r_acc    <= 64'd0;
          r_cnt    <= 5'd0;
          r_state  <= S_BUSY;
        end
        S_BUSY: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_hi    <= w_acc_next[63:32];
            r_lo    <= w_acc_next[31:0];
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
`else
  assign w_stall = 1'b0;
`endif

  always_comb begin
    w_alu = 32'd0;
    case (alu_op_in)
      OP_ADD:   w_alu = A_in + w_op2;
      OP_SUB:   w_alu = A_in - w_op2;
      OP_AND:   w_alu = A_in & w_op2;
      OP_OR:    w_alu = A_in | w_op2;
      OP_XOR:   w_alu = A_in ^ w_op2;
      OP_NOR:   w_alu = ~(A_in | w_op2);
      OP_SLT:   w_alu = {31'd0, $signed(A_in) < $signed(w_op2)};
      OP_SLTU:  w_alu = {31'd0, A_in < w_op2};
      OP_SLL:   w_alu = w_op2 << w_sh;
      OP_SRL:   w_alu = w_op2 >> w_sh;
      OP_SRA:   w_alu = $unsigned($signed(w_op2) >>> w_sh);
      OP_LUI:   w_alu = {ir_in[15:0], 16'h0000};
`ifdef IX_MULT_EN
      OP_MULTU: w_alu = r_lo;
      OP_MFHI:  w_alu = r_hi;
      OP_MFLO:  w_alu = r_lo;
`endif
      default:  w_alu = 32'd0;
    endcase
  end

  always_comb begin
    w_cond = 1'b0;
    case (branch_type_in)
      2'b00: w_cond = (A_in == B_in);
      2'b01: w_cond = (A_in != B_in);
      2'b10: w_cond = A_in[31] | (A_in == 32'd0);
      2'b11: w_cond = ~A_in[31] & (A_in != 32'd0);
      default: w_cond = 1'b0;
    endcase
  end

  assign w_taken   = valid_in & (is_jump_in | (is_branch_in & w_cond));
  assign stall_out = w_stall;

  logic        r_valid, r_taken;
  logic [31:0] r_pc, r_ir, r_res, r_b, r_tgt;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n || w_stall || !valid_in) begin
      r_valid <= 1'b0;
      r_taken <= 1'b0;
      r_pc    <= 32'd0;
      r_ir    <= 32'd0;
      r_res   <= 32'd0;
      r_b     <= 32'd0;
      r_tgt   <= 32'd0;
    end else begin
      r_valid <= 1'b1;
      r_taken <= w_taken;
      r_pc    <= pc_in;
      r_ir    <= ir_in;
      r_res   <= w_alu;
      r_b     <= B_in;
      r_tgt   <= is_jump_in ? w_j_tgt : w_br_tgt;
    end
  end

  assign valid_out         = r_valid;
  assign branch_taken_out  = r_taken;
  assign pc_out            = r_pc;
  assign ir_out            = r_ir;
  assign result_out        = r_res;
  assign B_out             = r_b;
  assign branch_target_out = r_tgt;
endmodule

// File: tb/tb_ix_stage.sv
// Bench for ix_stage: directed vectors, a spec-level behavioural model checked every cycle,
// and literal expectations for the headline cases.
`timescale 1ns/1ps
module tb_ix_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] pc_in = '0, ir_in = '0, A_in = '0, B_in = '0;
  logic [5:0]  alu_op_in = '0, shift_amount_in = '0;
  logic        is_branch_in = 1'b0, is_jump_in = 1'b0, op2_sel_in = 1'b0;
  logic [1:0]  branch_type_in = '0;
  logic        stall_out, valid_out, branch_taken_out;
  logic [31:0] pc_out, ir_out, result_out, B_out, branch_target_out;

  always #5 clk = ~clk;

  ix_stage dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .pc_in(pc_in), .ir_in(ir_in),
    .A_in(A_in), .B_in(B_in), .alu_op_in(alu_op_in), .is_branch_in(is_branch_in),
    .is_jump_in(is_jump_in), .op2_sel_in(op2_sel_in), .shift_amount_in(shift_amount_in),
    .branch_type_in(branch_type_in), .stall_out(stall_out), .valid_out(valid_out),
    .pc_out(pc_out), .ir_out(ir_out), .result_out(result_out), .B_out(B_out),
    .branch_taken_out(branch_taken_out), .branch_target_out(branch_target_out)
  );

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        e_valid = 1'b0, e_taken = 1'b0;
  logic [31:0] e_pc = '0, e_ir = '0, e_res = '0, e_b = '0, e_tgt = '0;
  logic [31:0] m_hi = '0, m_lo = '0, m_a = '0, m_b = '0;
  int          m_left = 0;  // edges remaining until the multiply retires (0 = none in flight)
  logic [63:0] m_prod;
  assign m_prod = {32'd0, m_a} * {32'd0, m_b};

  function automatic logic m_stall();
`ifdef IX_MULT_EN
    if (!rst_n) return 1'b0;
    if (m_left == 0) return valid_in && (alu_op_in == 6'h10);
    return m_left > 1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_alu(input logic [5:0] op, input logic [31:0] a,
                                        input logic [31:0] b2, input logic [4:0] sh,
                                        input logic [15:0] imm);
    case (op)
      6'h00: return a + b2;
      6'h01: return a - b2;
      6'h02: return a & b2;
      6'h03: return a | b2;
      6'h04: return a ^ b2;
      6'h05: return ~(a | b2);
      6'h06: return ($signed(a) < $signed(b2)) ? 32'd1 : 32'd0;
      6'h07: return (a < b2) ? 32'd1 : 32'd0;
      6'h08: return b2 << sh;
      6'h09: return b2 >> sh;
      6'h0A: return $unsigned($signed(b2) >>> sh);
      6'h0B: return {imm, 16'h0000};
`ifdef IX_MULT_EN
      6'h10: return m_lo;
      6'h11: return m_hi;
      6'h12: return m_lo;
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_cond(input logic [1:0] bt, input logic [31:0] a, input logic [31:0] b);
    case (bt)
      2'b00: return a == b;
      2'b01: return a != b;
      2'b10: return $signed(a) <= 0;
      default: return $signed(a) > 0;
    endcase
  endfunction

  function automatic logic [31:0] m_sext(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid <= 1'b0; e_taken <= 1'b0;
      e_pc <= '0; e_ir <= '0; e_res <= '0; e_b <= '0; e_tgt <= '0;
      m_hi <= '0; m_lo <= '0; m_left <= 0;
    end else begin
      if (m_left == 1) begin
        m_hi <= m_prod[63:32];
        m_lo <= m_prod[31:0];
      end
      if (m_stall() || !valid_in) begin
        e_valid <= 1'b0; e_taken <= 1'b0;
        e_pc <= '0; e_ir <= '0; e_res <= '0; e_b <= '0; e_tgt <= '0;
      end else begin
        e_valid <= 1'b1;
        e_taken <= is_jump_in | (is_branch_in & m_cond(branch_type_in, A_in, B_in));
        e_pc    <= pc_in;
        e_ir    <= ir_in;
        e_b     <= B_in;
        e_res   <= (m_left == 1) ? m_prod[31:0] :
                   m_alu(alu_op_in, A_in, op2_sel_in ? m_sext(ir_in[15:0]) : B_in,
                         shift_amount_in[4:0], ir_in[15:0]);
        e_tgt   <= is_jump_in ? {pc_in[31:28], ir_in[25:0], 2'b00}
                              : pc_in + 32'd4 + (m_sext(ir_in[15:0]) << 2);
      end
      if (m_left > 0) m_left <= m_left - 1;
      else if (m_stall()) begin
        m_a <= A_in; m_b <= B_in; m_left <= 33;
      end
    end
  end

  // Registered outputs are checked at posedge (mid-cycle); the combinational stall just after
  // the next input change.
  always @(posedge clk) begin
    if (chk_en) begin
      chk("valid_out", {31'd0, valid_out}, {31'd0, e_valid});
      chk("branch_taken_out", {31'd0, branch_taken_out}, {31'd0, e_taken});
      chk("pc_out", pc_out, e_pc);
      chk("ir_out", ir_out, e_ir);
      chk("result_out", result_out, e_res);
      chk("B_out", B_out, e_b);
      chk("branch_target_out", branch_target_out, e_tgt);
      #2;
      chk("stall_out", {31'd0, stall_out}, {31'd0, m_stall()});
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input logic v, input logic [5:0] op, input logic [31:0] pc,
                        input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b,
                        input logic sel, input logic [5:0] sh, input logic br, input logic jp,
                        input logic [1:0] bt);
    valid_in = v; alu_op_in = op; pc_in = pc; ir_in = ir; A_in = a; B_in = b;
    op2_sel_in = sel; shift_amount_in = sh; is_branch_in = br; is_jump_in = jp;
    branch_type_in = bt;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] pc,
                       input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b,
                       input logic sel, input logic [5:0] sh, input logic br, input logic jp,
                       input logic [1:0] bt);
    set_in(v, op, pc, ir, a, b, sel, sh, br, jp, bt);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_stall", {31'd0, stall_out}, 32'd0);
    chk("rst_result", result_out, 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    drive(1, 6'h00, 32'h200, 32'h0000FFFF, 32'h5, 32'h0, 1, 0, 0, 0, 0);
    chk("add_imm_result", result_out, 32'h4);
    chk("add_imm_valid", {31'd0, valid_out}, 32'd1);
    drive(1, 6'h0A, 32'h204, 32'h0, 32'h0, 32'h8000_0000, 0, 6'd4, 0, 0, 0);
    chk("sra_result", result_out, 32'hF800_0000);
    drive(1, 6'h06, 32'h208, 32'h0, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 0, 0);
    chk("slt_result", result_out, 32'h1);
    drive(1, 6'h07, 32'h20C, 32'h0, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 0, 0);
    chk("sltu_result", result_out, 32'h0);
    drive(1, 6'h01, 32'h100, 32'h0000FFFE, 32'h1, 32'h2, 0, 0, 1, 0, 2'b01);
    chk("bne_taken", {31'd0, branch_taken_out}, 32'd1);
    chk("bne_target", branch_target_out, 32'h0FC);
    drive(1, 6'h00, 32'h1000_0000, 32'h0800_0040, 32'h0, 32'h0, 0, 0, 0, 1, 0);
    chk("jump_taken", {31'd0, branch_taken_out}, 32'd1);
    chk("jump_target", branch_target_out, 32'h1000_0100);
    drive(1, 6'h0B, 32'h210, 32'h0000_1234, 32'h0, 32'h0, 0, 0, 0, 0, 0);
    chk("lui_result", result_out, 32'h1234_0000);
    drive(1, 6'h3F, 32'h214, 32'h0, 32'h1234, 32'h5678, 0, 0, 0, 0, 0);
    chk("unknown_op_result", result_out, 32'h0);
    drive(0, 6'h00, 32'h218, 32'h0800_0040, 32'h1, 32'h1, 0, 0, 0, 1, 0);
    chk("bubble_valid", {31'd0, valid_out}, 32'd0);
    chk("bubble_taken", {31'd0, branch_taken_out}, 32'd0);
    // model-only vectors
    drive(1, 6'h01, 32'h21C, 32'h0, 32'hA, 32'h3, 0, 0, 1, 0, 2'b00);
    drive(1, 6'h02, 32'h220, 32'h0000_F0F0, 32'hFFFF_00FF, 32'h0, 1, 0, 1, 0, 2'b00);
    drive(1, 6'h03, 32'h224, 32'h0, 32'h1200_0000, 32'h0000_0034, 0, 0, 0, 0, 0);
    drive(1, 6'h04, 32'h228, 32'h0, 32'hAAAA_5555, 32'hFFFF_0000, 0, 0, 0, 0, 0);
    drive(1, 6'h05, 32'h22C, 32'h0, 32'h0F0F_0000, 32'h0000_00F0, 0, 0, 0, 0, 0);
    drive(1, 6'h08, 32'h230, 32'h0, 32'h0, 32'h0000_0003, 0, 6'd31, 1, 0, 2'b10);
    drive(1, 6'h08, 32'h234, 32'h0, 32'h0, 32'h0000_0003, 0, 6'h21, 1, 0, 2'b11);
    drive(1, 6'h09, 32'h238, 32'h0, 32'h8000_0000, 32'h8000_0000, 0, 6'd31, 1, 0, 2'b11);
    drive(1, 6'h00, 32'h23C, 32'h0000_8000, 32'h7, 32'h0, 1, 0, 1, 0, 2'b11);
    drive(1, 6'h0A, 32'h240, 32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 0, 6'd0, 1, 0, 2'b10);

`ifdef IX_MULT_EN
    set_in(1, 6'h10, 32'h300, 32'h0, 32'hFFFF_FFFF, 32'h2, 0, 0, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (stall_out) n++;
      else break;
      @(posedge clk); #1;
    end
    chk("multu_stall_cycles", n, 33);
    @(posedge clk); #1;
    chk("multu_valid", {31'd0, valid_out}, 32'd1);
    chk("multu_result", result_out, 32'hFFFF_FFFE);
    drive(1, 6'h11, 32'h304, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
    chk("mfhi_result", result_out, 32'h1);
    drive(1, 6'h12, 32'h308, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
    chk("mflo_result", result_out, 32'hFFFF_FFFE);
    set_in(1, 6'h10, 32'h30C, 32'h0, 32'h7, 32'h9, 0, 0, 0, 0, 0);
    repeat (11) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midmul_rst_stall", {31'd0, stall_out}, 32'd0);
    @(posedge clk); #1;
    set_in(0, 6'h00, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    drive(1, 6'h11, 32'h310, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
    chk("midmul_hi_cleared", result_out, 32'h0);
    drive(1, 6'h12, 32'h314, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
    chk("midmul_lo_cleared", result_out, 32'h0);
`else
    set_in(1, 6'h10, 32'h300, 32'h0, 32'hFFFF_FFFF, 32'h2, 0, 0, 0, 0, 0);
    #1;
    chk("nomul_stall", {31'd0, stall_out}, 32'd0);
    @(posedge clk); #1;
    chk("nomul_valid", {31'd0, valid_out}, 32'd1);
    chk("nomul_result", result_out, 32'h0);
    drive(1, 6'h11, 32'h304, 32'h0, 32'h5, 32'h6, 0, 0, 0, 0, 0);
    chk("nomul_mfhi_result", result_out, 32'h0);
`endif

    // reset asserted mid-stream with a valid MULTU presented: outputs clear without a clock edge
    drive(1, 6'h00, 32'h400, 32'h0, 32'h11, 32'h22, 0, 0, 0, 1, 0);
    set_in(1, 6'h10, 32'h404, 32'h0, 32'h3, 32'h4, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, valid_out}, 32'd0);
    chk("async_rst_taken", {31'd0, branch_taken_out}, 32'd0);
    chk("async_rst_pc", pc_out, 32'd0);
    chk("async_rst_result", result_out, 32'd0);
    chk("async_rst_target", branch_target_out, 32'd0);
    chk("async_rst_stall", {31'd0, stall_out}, 32'd0);
    @(posedge clk); #1;
    set_in(0, 6'h00, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    drive(1, 6'h00, 32'h408, 32'h0000_0010, 32'h20, 32'h0, 1, 0, 0, 0, 0);
    chk("post_rst_add", result_out, 32'h30);
    drive(0, 6'h00, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
